// File: rtl/alu_result_monitor.sv
// ---------------------------------------------------------------------------
// alu_result_monitor
//
// Checks a stream of 8-bit ALU results against a built-in reference model.
// A run starts on 'start'. Each in_valid beat in the run is compared with the
// expected {c_out,sum}. The run ends after num_vec beats, and pass then reports
// whether every beat matched.
//
// Optional feature: define ALU_RESULT_MONITOR_CAPTURE_EN to build the
// first-failure capture registers. Without it, the fail_* outputs are tied to 0.
//
// Ports
//   clk        : clock, all state updates on the rising edge
//   rst        : synchronous active-high reset, priority over everything
//   start      : begin a run (accepted in IDLE or DONE, ignored in RUN)
//   num_vec    : beats in the run, latched when start is accepted
//   in_valid   : a/b/c_in/oper/sum/c_out form one beat this cycle
//   a, b, c_in : ALU operands
//   oper       : ALU opcode
//   sum, c_out : ALU result under check
//   busy       : run in progress (RUN)
//   done       : run finished (DONE)
//   pass       : DONE with no mismatches
//   vec_cnt    : beats checked in the current run
//   err_cnt    : mismatching beats, saturates at 255
//   fail_*     : operands/result of the first mismatching beat
// ---------------------------------------------------------------------------
module alu_result_monitor #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_vec,
  input  logic             in_valid,
  input  logic [7:0]       a,
  input  logic [7:0]       b,
  input  logic             c_in,
  input  logic [2:0]       oper,
  input  logic [7:0]       sum,
  input  logic             c_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] vec_cnt,
  output logic [7:0]       err_cnt,
  output logic [2:0]       fail_oper,
  output logic [7:0]       fail_a,
  output logic [7:0]       fail_b,
  output logic [7:0]       fail_sum,
  output logic             fail_cout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] vec_cnt_reg, vec_cnt_next;
  logic [CNT_W-1:0] target_reg, target_next;
  logic [7:0]       err_cnt_reg, err_cnt_next;
  logic [CNT_W-1:0] vec_inc;
  logic [8:0]       exp_result;
  logic             mismatch;

  // Reference model: 9-bit result, bit 8 is the carry out.
  // Logic opcodes never produce a carry.
  always_comb begin
    exp_result = 9'd0;
    case (oper)
      3'b000:  exp_result = {1'b0, a} + {1'b0, b} + {8'd0, c_in};
      3'b001:  exp_result = {1'b0, a} + {1'b0, ~b} + {8'd0, c_in};
      3'b010:  exp_result = {1'b0, b} + {1'b0, ~a} + {8'd0, c_in};
      3'b011:  exp_result = {1'b0, a | b};
      3'b100:  exp_result = {1'b0, a & b};
      3'b101:  exp_result = {1'b0, ~a & b};
      3'b110:  exp_result = {1'b0, a ^ b};
      default: exp_result = {1'b0, ~(a ^ b)};
    endcase
  end

  assign mismatch = (exp_result != {c_out, sum});
  assign vec_inc  = vec_cnt_reg + 1'b1;

  // State register and counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      vec_cnt_reg <= '0;
      target_reg  <= '0;
      err_cnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      vec_cnt_reg <= vec_cnt_next;
      target_reg  <= target_next;
      err_cnt_reg <= err_cnt_next;
    end
  end

  // Next-state and counter logic.
  always_comb begin
    state_next   = state_reg;
    vec_cnt_next = vec_cnt_reg;
    target_next  = target_reg;
    err_cnt_next = err_cnt_reg;
    case (state_reg)
      IDLE, DONE: begin
        if (start) begin
          vec_cnt_next = '0;
          err_cnt_next = '0;
          target_next  = num_vec;
          state_next   = (num_vec == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (in_valid) begin
          vec_cnt_next = vec_inc;
          if (mismatch && (err_cnt_reg != 8'hFF)) begin
            err_cnt_next = err_cnt_reg + 8'd1;
          end
          // The final beat leaves RUN on the same edge, so vec_cnt can never
          // run past the target.
          if (vec_inc == target_reg) begin
            state_next = DONE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy    = (state_reg == RUN);
  assign done    = (state_reg == DONE);
  assign pass    = (state_reg == DONE) && (err_cnt_reg == 8'd0);
  assign vec_cnt = vec_cnt_reg;
  assign err_cnt = err_cnt_reg;

`ifdef ALU_RESULT_MONITOR_CAPTURE_EN
  logic [2:0] fail_oper_reg;
  logic [7:0] fail_a_reg;
  logic [7:0] fail_b_reg;
  logic [7:0] fail_sum_reg;
  logic       fail_cout_reg;
  logic       capture_clear;
  logic       capture_load;

  assign capture_clear = start && (state_reg != RUN);
  // err_cnt is still zero only before the first mismatch of the run.
  assign capture_load  = (state_reg == RUN) && in_valid && mismatch &&
                         (err_cnt_reg == 8'd0);

  always_ff @(posedge clk) begin
    if (rst || capture_clear) begin
      fail_oper_reg <= '0;
      fail_a_reg    <= '0;
      fail_b_reg    <= '0;
      fail_sum_reg  <= '0;
      fail_cout_reg <= 1'b0;
    end else if (capture_load) begin
      fail_oper_reg <= oper;
      fail_a_reg    <= a;
      fail_b_reg    <= b;
      fail_sum_reg  <= sum;
      fail_cout_reg <= c_out;
    end
  end

  assign fail_oper = fail_oper_reg;
  assign fail_a    = fail_a_reg;
  assign fail_b    = fail_b_reg;
  assign fail_sum  = fail_sum_reg;
  assign fail_cout = fail_cout_reg;
`else
  assign fail_oper = 3'd0;
  assign fail_a    = 8'd0;
  assign fail_b    = 8'd0;
  assign fail_sum  = 8'd0;
  assign fail_cout = 1'b0;
`endif

endmodule

// File: tb/tb_alu_result_monitor.sv
// ---------------------------------------------------------------------------
// tb_alu_result_monitor
//
// Directed testbench for alu_result_monitor. It uses hand-computed expected
// values and prints one line per beat applied.
// ---------------------------------------------------------------------------
module tb_alu_result_monitor;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [CNT_W-1:0] num_vec;
  logic             in_valid;
  logic [7:0]       a, b;
  logic             c_in;
  logic [2:0]       oper;
  logic [7:0]       sum;
  logic             c_out;
  logic             busy, done, pass;
  logic [CNT_W-1:0] vec_cnt;
  logic [7:0]       err_cnt;
  logic [2:0]       fail_oper;
  logic [7:0]       fail_a, fail_b, fail_sum;
  logic             fail_cout;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  alu_result_monitor #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .num_vec(num_vec),
    .in_valid(in_valid), .a(a), .b(b), .c_in(c_in), .oper(oper),
    .sum(sum), .c_out(c_out), .busy(busy), .done(done), .pass(pass),
    .vec_cnt(vec_cnt), .err_cnt(err_cnt), .fail_oper(fail_oper),
    .fail_a(fail_a), .fail_b(fail_b), .fail_sum(fail_sum),
    .fail_cout(fail_cout)
  );

  // Advance one clock edge. Outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [CNT_W-1:0] n);
    start   = 1'b1;
    num_vec = n;
    tick();
    start   = 1'b0;
  endtask

  task automatic beat(input logic [2:0] op, input logic [7:0] aa,
                      input logic [7:0] bb, input logic ci,
                      input logic [7:0] s, input logic co);
    in_valid = 1'b1;
    oper = op; a = aa; b = bb; c_in = ci; sum = s; c_out = co;
    tick();
    in_valid = 1'b0;
    $display("beat oper=%0d a=%h b=%h c_in=%0d sum=%h c_out=%0d -> vec_cnt=%0d err_cnt=%0d busy=%0d done=%0d",
             op, aa, bb, ci, s, co, vec_cnt, err_cnt, busy, done);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; num_vec = '0; in_valid = 1'b0;
    a = '0; b = '0; c_in = 1'b0; oper = '0; sum = '0; c_out = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    vectors++;
    if ({busy, done, pass} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_status busy/done/pass=%b expected 000", {busy, done, pass});
    end
    vectors++;
    if (vec_cnt !== 16'd0 || err_cnt !== 8'd0) begin
      miscompares++;
      $display("FAIL reset_counts vec=%0d err=%0d expected 0/0", vec_cnt, err_cnt);
    end
    vectors++;
    if ({fail_oper, fail_a, fail_b, fail_sum, fail_cout} !== 28'd0) begin
      miscompares++;
      $display("FAIL reset_capture got %h expected 0",
               {fail_oper, fail_a, fail_b, fail_sum, fail_cout});
    end
  endtask

  // Four correct ADD beats: FF + 01 + 0 = 1_00.
  task automatic test_add_pass();
    do_start(16'd4);
    vectors++;
    if (busy !== 1'b1 || vec_cnt !== 16'd0) begin
      miscompares++;
      $display("FAIL add_start busy=%0d vec=%0d expected 1/0", busy, vec_cnt);
    end
    for (int i = 0; i < 4; i++) begin
      beat(3'b000, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
      vectors++;
      if (vec_cnt !== 16'(i + 1)) begin
        miscompares++;
        $display("FAIL add_vec_cnt got %0d expected %0d", vec_cnt, i + 1);
      end
    end
    vectors++;
    if ({busy, done, pass} !== 3'b011 || err_cnt !== 8'd0) begin
      miscompares++;
      $display("FAIL add_done busy/done/pass=%b err=%0d expected 011/0",
               {busy, done, pass}, err_cnt);
    end
    // A beat in DONE is ignored.
    beat(3'b000, 8'h00, 8'h00, 1'b0, 8'h55, 1'b0);
    vectors++;
    if (vec_cnt !== 16'd4 || err_cnt !== 8'd0) begin
      miscompares++;
      $display("FAIL done_ignores_beat vec=%0d err=%0d expected 4/0", vec_cnt, err_cnt);
    end
  endtask

  // Beat 2 is XOR 0F^F0 = FF, but it reports 00.
  task automatic test_xor_fail();
    logic [2:0] exp_op;
    logic [7:0] exp_a, exp_b;
`ifdef ALU_RESULT_MONITOR_CAPTURE_EN
    exp_op = 3'd6; exp_a = 8'h0F; exp_b = 8'hF0;
`else
    exp_op = 3'd0; exp_a = 8'h00; exp_b = 8'h00;
`endif
    do_start(16'd3);
    vectors++;
    if (vec_cnt !== 16'd0 || err_cnt !== 8'd0) begin
      miscompares++;
      $display("FAIL restart_clear vec=%0d err=%0d expected 0/0", vec_cnt, err_cnt);
    end
    beat(3'b000, 8'h10, 8'h20, 1'b1, 8'h31, 1'b0);
    beat(3'b110, 8'h0F, 8'hF0, 1'b0, 8'h00, 1'b0);
    vectors++;
    if (err_cnt !== 8'd1) begin
      miscompares++;
      $display("FAIL xor_err_latency got %0d expected 1", err_cnt);
    end
    beat(3'b111, 8'h0F, 8'hF0, 1'b0, 8'h00, 1'b0);
    vectors++;
    if ({done, pass} !== 2'b10 || err_cnt !== 8'd1 || vec_cnt !== 16'd3) begin
      miscompares++;
      $display("FAIL xor_done done/pass=%b err=%0d vec=%0d expected 10/1/3",
               {done, pass}, err_cnt, vec_cnt);
    end
    vectors++;
    if (fail_oper !== exp_op || fail_a !== exp_a || fail_b !== exp_b ||
        fail_sum !== 8'h00 || fail_cout !== 1'b0) begin
      miscompares++;
      $display("FAIL xor_capture oper=%0d a=%h b=%h sum=%h cout=%0d expected %0d/%h/%h/00/0",
               fail_oper, fail_a, fail_b, fail_sum, fail_cout, exp_op, exp_a, exp_b);
    end
  endtask

  // Every beat is wrong. The first is OR 01|02=03 with sum 00 and c_out 1.
  // The rest are XOR 00^00=00 with sum 01.
  task automatic test_saturate();
    logic [2:0] exp_op;
    logic       exp_co;
`ifdef ALU_RESULT_MONITOR_CAPTURE_EN
    exp_op = 3'd3; exp_co = 1'b1;
`else
    exp_op = 3'd0; exp_co = 1'b0;
`endif
    do_start(16'd300);
    beat(3'b011, 8'h01, 8'h02, 1'b0, 8'h00, 1'b1);
    for (int i = 2; i <= 300; i++) begin
      beat(3'b110, 8'h00, 8'h00, 1'b0, 8'h01, 1'b0);
      if (i == 100) begin
        tick();
        tick();
        vectors++;
        if (vec_cnt !== 16'd100 || err_cnt !== 8'd100 || busy !== 1'b1) begin
          miscompares++;
          $display("FAIL idle_hold vec=%0d err=%0d busy=%0d expected 100/100/1",
                   vec_cnt, err_cnt, busy);
        end
      end
      if (i == 255 || i == 256) begin
        vectors++;
        if (err_cnt !== 8'd255) begin
          miscompares++;
          $display("FAIL sat_at_%0d err=%0d expected 255", i, err_cnt);
        end
      end
    end
    vectors++;
    if (vec_cnt !== 16'd300 || err_cnt !== 8'd255 || {busy, done, pass} !== 3'b010) begin
      miscompares++;
      $display("FAIL sat_done vec=%0d err=%0d bdp=%b expected 300/255/010",
               vec_cnt, err_cnt, {busy, done, pass});
    end
    vectors++;
    if (fail_oper !== exp_op || fail_cout !== exp_co) begin
      miscompares++;
      $display("FAIL sat_capture_first oper=%0d cout=%0d expected %0d/%0d",
               fail_oper, fail_cout, exp_op, exp_co);
    end
  endtask

  task automatic test_zero_and_start_in_run();
    do_start(16'd0);
    vectors++;
    if ({busy, done, pass} !== 3'b011 || vec_cnt !== 16'd0 || err_cnt !== 8'd0) begin
      miscompares++;
      $display("FAIL zero_run bdp=%b vec=%0d err=%0d expected 011/0/0",
               {busy, done, pass}, vec_cnt, err_cnt);
    end
    do_start(16'd5);
    beat(3'b000, 8'h01, 8'h01, 1'b0, 8'h02, 1'b0);
    // A start pulse in RUN must not clear the counters or reload the target.
    start = 1'b1; num_vec = 16'd2;
    tick();
    start = 1'b0;
    vectors++;
    if (vec_cnt !== 16'd1 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL start_in_run vec=%0d busy=%0d expected 1/1", vec_cnt, busy);
    end
    for (int i = 0; i < 4; i++) begin
      beat(3'b000, 8'h01, 8'h01, 1'b0, 8'h02, 1'b0);
    end
    vectors++;
    if (vec_cnt !== 16'd5 || {busy, done, pass} !== 3'b011) begin
      miscompares++;
      $display("FAIL start_in_run_end vec=%0d bdp=%b expected 5/011",
               vec_cnt, {busy, done, pass});
    end
  endtask

  task automatic test_reset_midrun();
    do_start(16'd5);
    beat(3'b100, 8'hF0, 8'h3C, 1'b0, 8'h00, 1'b0);
    beat(3'b100, 8'hF0, 8'h3C, 1'b0, 8'h30, 1'b0);
    // Reset takes priority over a simultaneous start and beat.
    rst = 1'b1; start = 1'b1; num_vec = 16'd1; in_valid = 1'b1;
    oper = 3'b000; a = 8'h00; b = 8'h00; sum = 8'hAA; c_out = 1'b0;
    tick();
    rst = 1'b0; start = 1'b0; in_valid = 1'b0;
    vectors++;
    if ({busy, done, pass} !== 3'b000 || vec_cnt !== 16'd0 || err_cnt !== 8'd0 ||
        {fail_oper, fail_a, fail_b, fail_sum, fail_cout} !== 28'd0) begin
      miscompares++;
      $display("FAIL midrun_reset bdp=%b vec=%0d err=%0d cap=%h expected all 0",
               {busy, done, pass}, vec_cnt, err_cnt,
               {fail_oper, fail_a, fail_b, fail_sum, fail_cout});
    end
    do_start(16'd2);
    beat(3'b000, 8'h80, 8'h80, 1'b1, 8'h01, 1'b1);
    vectors++;
    if (vec_cnt !== 16'd1 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL after_reset_vec vec=%0d busy=%0d expected 1/1", vec_cnt, busy);
    end
    beat(3'b000, 8'h80, 8'h80, 1'b1, 8'h01, 1'b1);
    vectors++;
    if ({busy, done, pass} !== 3'b011 || err_cnt !== 8'd0) begin
      miscompares++;
      $display("FAIL after_reset_done bdp=%b err=%0d expected 011/0",
               {busy, done, pass}, err_cnt);
    end
  endtask

  // 05 + ~07 + 1 = 0_FE. A result with c_out=1 is wrong.
  // 07 + ~05 + 0 = 1_01.
  task automatic test_subtract();
    do_start(16'd3);
    beat(3'b001, 8'h05, 8'h07, 1'b1, 8'hFE, 1'b0);
    vectors++;
    if (err_cnt !== 8'd0) begin
      miscompares++;
      $display("FAIL sub_correct err=%0d expected 0", err_cnt);
    end
    beat(3'b001, 8'h05, 8'h07, 1'b1, 8'hFE, 1'b1);
    vectors++;
    if (err_cnt !== 8'd1) begin
      miscompares++;
      $display("FAIL sub_bad_carry err=%0d expected 1", err_cnt);
    end
    beat(3'b010, 8'h05, 8'h07, 1'b0, 8'h01, 1'b1);
    vectors++;
    if (err_cnt !== 8'd1 || done !== 1'b1) begin
      miscompares++;
      $display("FAIL rsub_correct err=%0d done=%0d expected 1/1", err_cnt, done);
    end
  endtask

  // a=3C, b=A5, c_in=1. Logic ops must give c_out=0.
  task automatic test_logic_ops();
    do_start(16'd6);
    beat(3'b011, 8'h3C, 8'hA5, 1'b1, 8'hBD, 1'b0);
    beat(3'b100, 8'h3C, 8'hA5, 1'b1, 8'h24, 1'b0);
    beat(3'b101, 8'h3C, 8'hA5, 1'b1, 8'h81, 1'b0);
    beat(3'b110, 8'h3C, 8'hA5, 1'b1, 8'h99, 1'b0);
    beat(3'b111, 8'h3C, 8'hA5, 1'b1, 8'h66, 1'b0);
    vectors++;
    if (err_cnt !== 8'd0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL logic_correct err=%0d busy=%0d expected 0/1", err_cnt, busy);
    end
    beat(3'b011, 8'h3C, 8'hA5, 1'b1, 8'hBD, 1'b1);
    vectors++;
    if (err_cnt !== 8'd1 || {done, pass} !== 2'b10) begin
      miscompares++;
      $display("FAIL logic_carry err=%0d done/pass=%b expected 1/10", err_cnt, {done, pass});
    end
  endtask

  initial begin
    test_reset();
    test_add_pass();
    test_xor_fail();
    test_saturate();
    test_zero_and_start_in_run();
    test_reset_midrun();
    test_subtract();
    test_logic_ops();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
